bool_sweep_checker: RTL and testbench



---
 rtl/bool_pkg.sv | 24 ++
 rtl/bool_vec_cmp.sv | 21 ++
 rtl/bool_sweep_checker.sv | 125 ++++++++++++
 tb/tb_bool_sweep_checker.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bool_pkg.sv
// ---------------------------------------------------------------------------
// bool_pkg -- shared types and constants for the 4-input Boolean sweep.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package bool_pkg;

  localparam int unsigned VEC_W = 4;
  localparam int unsigned N_VEC = 1 << VEC_W;

  // Bit i is F for {W,X,Y,Z} = i.
  localparam logic [N_VEC-1:0] Q4_TT = 16'hF3C3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CHECK  = 2'd2,
    ST_DONE   = 2'd3
  } sweep_state_e;

endpackage

`default_nettype wire

// File: rtl/bool_vec_cmp.sv
// ---------------------------------------------------------------------------
// bool_vec_cmp -- flags a vector as failed when any implementation is wrong.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module bool_vec_cmp (
  input  logic f_dataflow,
  input  logic f_behavioral,
  input  logic f_structural,
  input  logic expected,
  output logic fail
);

  assign fail = (f_dataflow   ^ expected) |
                (f_behavioral ^ expected) |
                (f_structural ^ expected);

endmodule

`default_nettype wire

// File: rtl/bool_sweep_checker.sv
// ---------------------------------------------------------------------------
// bool_sweep_checker -- drives all 16 vectors to three F implementations,
// samples after a settle interval and scores them against a truth table.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module bool_sweep_checker
  import bool_pkg::*;
#(
  parameter logic [15:0] EXPECTED = Q4_TT,
  parameter int unsigned SETTLE   = 2      // legal range 1..15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [VEC_W-1:0] vec_out,
  input  logic             f_dataflow,
  input  logic             f_behavioral,
  input  logic             f_structural,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [4:0]       err_count,
  output logic [15:0]      mismatch_mask,
  output logic [VEC_W-1:0] first_fail_idx,
  output logic             first_fail_valid
);

  localparam logic [3:0]       SETTLE_M1 = 4'(SETTLE - 1);
  localparam logic [VEC_W-1:0] LAST_VEC  = '1;

  sweep_state_e     state_q;
  logic [VEC_W-1:0] vec_q;
  logic [3:0]       cnt_q;
  logic             busy_q;
  logic             done_q;
  logic             pass_q;
  logic [4:0]       err_cnt_q;
  logic [4:0]       err_cnt_d;
  logic [15:0]      mask_q;
  logic [VEC_W-1:0] ff_idx_q;
  logic             ff_valid_q;
  logic             fail;

  bool_vec_cmp u_cmp (
    .f_dataflow   (f_dataflow),
    .f_behavioral (f_behavioral),
    .f_structural (f_structural),
    .expected     (EXPECTED[vec_q]),
    .fail         (fail)
  );

  assign err_cnt_d = err_cnt_q + {4'd0, fail};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      vec_q      <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      err_cnt_q  <= '0;
      mask_q     <= '0;
      ff_idx_q   <= '0;
      ff_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_q    <= ST_SETTLE;
            vec_q      <= '0;
            cnt_q      <= '0;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            err_cnt_q  <= '0;
            mask_q     <= '0;
            ff_idx_q   <= '0;
            ff_valid_q <= 1'b0;
          end
        end
        ST_SETTLE: begin
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == SETTLE_M1) state_q <= ST_CHECK;
        end
        ST_CHECK: begin
          if (fail) begin
            mask_q[vec_q] <= 1'b1;
            err_cnt_q     <= err_cnt_d;
            if (!ff_valid_q) begin
              ff_idx_q   <= vec_q;
              ff_valid_q <= 1'b1;
            end
          end
          if (vec_q == LAST_VEC) begin
            // pass must see this last vector's outcome, hence err_cnt_d.
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (err_cnt_d == 5'd0);
          end else begin
            state_q <= ST_SETTLE;
            vec_q   <= vec_q + 1'b1;
            cnt_q   <= '0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign vec_out          = vec_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign pass             = pass_q;
  assign err_count        = err_cnt_q;
  assign mismatch_mask    = mask_q;
  assign first_fail_idx   = ff_idx_q;
  assign first_fail_valid = ff_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_bool_sweep_checker.sv
// ---------------------------------------------------------------------------
// tb_bool_sweep_checker -- directed sweeps against a timing/result model.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_bool_sweep_checker;

  localparam logic [15:0] TT = 16'hF3C3;

  logic clk = 1'b0;
  logic rst;
  logic start0, start1;
  int   mode0, mode1;

  logic [3:0]  vec0, vec1, ffi0, ffi1;
  logic        fd0, fb0, fs0, fd1, fb1, fs1;
  logic        busy0, done0, pass0, ffv0, busy1, done1, pass1, ffv1;
  logic [4:0]  err0, err1;
  logic [15:0] mask0, mask1;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  bool_sweep_checker #(.EXPECTED(16'hF3C3), .SETTLE(2)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .vec_out(vec0),
    .f_dataflow(fd0), .f_behavioral(fb0), .f_structural(fs0),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
    .mismatch_mask(mask0), .first_fail_idx(ffi0), .first_fail_valid(ffv0)
  );

  bool_sweep_checker #(.EXPECTED(16'hF3C3), .SETTLE(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .vec_out(vec1),
    .f_dataflow(fd1), .f_behavioral(fb1), .f_structural(fs1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .mismatch_mask(mask1), .first_fail_idx(ffi1), .first_fail_valid(ffv1)
  );

  // Stimulus "implementations": which = 0 dataflow, 1 behavioral, 2 structural.
  // mode 0 all correct, 1 structural stuck at 0, 2 behavioral wrong at 5,
  // 3 dataflow wrong at 14 and 15.
  function automatic logic f_impl(input int mode, input int which, input logic [3:0] v);
    logic e;
    e = TT[v];
    case (mode)
      1: if (which == 2) return 1'b0;
      2: if (which == 1 && v == 4'd5) return ~e;
      3: if (which == 0 && v >= 4'd14) return ~e;
      default: ;
    endcase
    return e;
  endfunction

  always_comb begin
    fd0 = f_impl(mode0, 0, vec0);
    fb0 = f_impl(mode0, 1, vec0);
    fs0 = f_impl(mode0, 2, vec0);
    fd1 = f_impl(mode1, 0, vec1);
    fb1 = f_impl(mode1, 1, vec1);
    fs1 = f_impl(mode1, 2, vec1);
  end

  function automatic logic [15:0] fail_mask_of(input int mode);
    logic [15:0] m;
    m = '0;
    for (int i = 0; i < 16; i++) begin
      logic e;
      e = TT[i];
      if (f_impl(mode, 0, 4'(i)) != e || f_impl(mode, 1, 4'(i)) != e ||
          f_impl(mode, 2, 4'(i)) != e)
        m[i] = 1'b1;
    end
    return m;
  endfunction

  task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: per instance, edges elapsed since the accepted start and the
  // failure set the chosen stimulus produces.
  bit          m_has [2];
  int          m_t   [2];
  logic [15:0] m_fm  [2];
  int          m_p   [2];

  initial begin
    m_p[0] = 3;
    m_p[1] = 2;
  end

  task automatic model_step(input int i, input logic st, input int mode);
    if (rst) begin
      m_has[i] = 1'b0;
    end else if (st && !(m_has[i] && m_t[i] < 16 * m_p[i])) begin
      m_has[i] = 1'b1;
      m_t[i]   = 0;
      m_fm[i]  = fail_mask_of(mode);
    end else if (m_has[i]) begin
      m_t[i]++;
    end
  endtask

  task automatic model_check(input int i, input logic [3:0] vec, input logic busy,
                             input logic done, input logic pass, input logic [4:0] err,
                             input logic [15:0] mask, input logic [3:0] ffi, input logic ffv);
    logic [15:0] e_mask;
    int n, e_err, e_vec, e_ffi;
    logic e_busy, e_done, e_pass;
    string p;
    p = (i == 0) ? "s2" : "s1";
    e_mask = '0; e_err = 0; e_vec = 0; e_ffi = 0;
    e_busy = 0; e_done = 0; e_pass = 0;
    if (m_has[i]) begin
      n = m_t[i] / m_p[i];
      if (n >= 16) begin
        n = 16; e_vec = 15; e_done = 1;
      end else begin
        e_vec = n; e_busy = 1;
      end
      for (int j = 0; j < n; j++) if (m_fm[i][j]) e_mask[j] = 1'b1;
      for (int j = 15; j >= 0; j--) if (e_mask[j]) e_ffi = j;
      e_err  = $countones(e_mask);
      e_pass = e_done && (e_err == 0);
    end
    cmp({p, ".vec_out"},          {12'd0, vec},  16'(e_vec));
    cmp({p, ".busy"},             {15'd0, busy}, {15'd0, e_busy});
    cmp({p, ".done"},             {15'd0, done}, {15'd0, e_done});
    cmp({p, ".pass"},             {15'd0, pass}, {15'd0, e_pass});
    cmp({p, ".err_count"},        {11'd0, err},  16'(e_err));
    cmp({p, ".mismatch_mask"},    mask,          e_mask);
    cmp({p, ".first_fail_idx"},   {12'd0, ffi},  16'(e_ffi));
    cmp({p, ".first_fail_valid"}, {15'd0, ffv},  {15'd0, (e_mask != 0)});
  endtask

  always @(posedge clk) begin
    cyc++;
    model_step(0, start0, mode0);
    model_step(1, start1, mode1);
    #1;
    model_check(0, vec0, busy0, done0, pass0, err0, mask0, ffi0, ffv0);
    model_check(1, vec1, busy1, done1, pass1, err1, mask1, ffi1, ffv1);
  end

  // Pulses start on one instance and returns edges from acceptance to done.
  task automatic sweep(input int inst, input int mode, input int extra_at, output int lat);
    int k, n;
    if (inst == 0) mode0 = mode; else mode1 = mode;
    @(negedge clk);
    if (inst == 0) start0 = 1'b1; else start1 = 1'b1;
    @(posedge clk); #1;
    k = cyc;
    @(negedge clk);
    start0 = 1'b0; start1 = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == extra_at) begin
        if (inst == 0) start0 = 1'b1; else start1 = 1'b1;
      end else begin
        start0 = 1'b0; start1 = 1'b0;
      end
    end while (((inst == 0) ? !done0 : !done1) && n < 200);
    lat = cyc - k;
    if (n >= 200) begin
      n_cmp++; n_fail++;
      $display("FAIL timeout: done not seen after %0d cycles", n);
    end
  endtask

  initial begin
    int lat;
    rst = 1'b1; start0 = 1'b0; start1 = 1'b0; mode0 = 0; mode1 = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cmp("reset.done", {15'd0, done0}, 16'd0);
    cmp("reset.vec",  {12'd0, vec0},  16'd0);

    cmp("model.mask_stuck0", fail_mask_of(1), 16'hF3C3);
    cmp("model.mask_bh5",    fail_mask_of(2), 16'h0020);

    sweep(0, 0, 0, lat);
    cmp("clean.latency", 16'(lat), 16'd48);
    cmp("clean.err",  {11'd0, err0}, 16'd0);
    cmp("clean.pass", {15'd0, pass0}, 16'd1);
    cmp("clean.ffv",  {15'd0, ffv0}, 16'd0);

    // Restart from DONE, with a stray start mid-sweep.
    sweep(0, 1, 10, lat);
    cmp("stuck.latency", 16'(lat), 16'd48);
    cmp("stuck.err",  {11'd0, err0}, 16'd10);
    cmp("stuck.mask", mask0, 16'hF3C3);
    cmp("stuck.ffi",  {12'd0, ffi0}, 16'd0);
    cmp("stuck.pass", {15'd0, pass0}, 16'd0);

    sweep(0, 2, 0, lat);
    cmp("bh5.err",  {11'd0, err0}, 16'd1);
    cmp("bh5.mask", mask0, 16'h0020);
    cmp("bh5.ffi",  {12'd0, ffi0}, 16'd5);

    sweep(0, 3, 0, lat);
    cmp("df1415.err",  {11'd0, err0}, 16'd2);
    cmp("df1415.mask", mask0, 16'hC000);
    cmp("df1415.ffi",  {12'd0, ffi0}, 16'd14);

    // Reset mid-sweep after failures have been recorded.
    mode0 = 1;
    @(negedge clk); start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    repeat (19) @(negedge clk);
    rst = 1'b1;
    #1;
    cmp("rst.busy", {15'd0, busy0}, 16'd0);
    cmp("rst.mask", mask0, 16'd0);
    cmp("rst.err",  {11'd0, err0}, 16'd0);
    cmp("rst.vec",  {12'd0, vec0}, 16'd0);
    @(negedge clk); rst = 1'b0;
    repeat (3) @(negedge clk);
    cmp("rst.no_resume", {15'd0, busy0}, 16'd0);

    sweep(0, 0, 0, lat);
    cmp("post_rst.latency", 16'(lat), 16'd48);
    cmp("post_rst.pass", {15'd0, pass0}, 16'd1);

    sweep(1, 1, 0, lat);
    cmp("s1.latency", 16'(lat), 16'd32);
    cmp("s1.err", {11'd0, err1}, 16'd10);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
